// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O window for a CPU data port.
// An IN0 holding register takes words from an external producer.
// A byte-wide TX FIFO feeds an external consumer.
// Optional feature macro: IO_BRIDGE_IRQ_EN adds the IRQ_CTL register and the registered irq output.
module io_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        io_sel,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
`ifdef IO_BRIDGE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        REG_IN0      = 3'd0,
        REG_IN_STAT  = 3'd1,
        REG_OUT_DATA = 3'd2,
        REG_OUT_STAT = 3'd3,
        REG_IRQ_CTL  = 3'd4
    } reg_off_e;

    logic [31:0]   r_in0;
    logic          r_full;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic [2:0]    w_off;
    logic          w_in_clr;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_stat_clr;
    logic [4:0]    w_count5;
    logic          w_unused;

`ifdef IO_BRIDGE_IRQ_EN
    logic [1:0]    r_irq_ctl;
    logic          r_irq;
    logic          w_irq_wr;
`endif

    // Address decode and per-register strobes.
    always_comb begin
        io_sel       = (Addr[31:16] == 16'h0000) && (Addr[15:5] == IO_BASE[15:5]);
        w_off        = Addr[4:2];
        w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
        w_fifo_empty = (r_count == '0);
        w_count5     = 5'(r_count);
        w_in_clr     = io_sel && MemRead && (w_off == REG_IN0) && r_full;
        w_push       = io_sel && MemWrite && (w_off == REG_OUT_DATA);
        w_pop        = !w_fifo_empty && out_ready;
        // Full FIFO still accepts a push when the head leaves on the same edge.
        w_push_ok    = w_push && (!w_fifo_full || w_pop);
        w_stat_clr   = io_sel && MemWrite && (w_off == REG_OUT_STAT) && WriteData[2];
        in_ready     = !r_full;
        out_valid    = !w_fifo_empty;
        out_data     = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
        w_unused     = &{1'b0, WriteData[31:8], Addr[1:0]};
    end

    // Register read mux; unmapped offsets and non-window addresses read zero.
    always_comb begin
        ReadData = '0;
        if (io_sel) begin
            case (w_off)
                REG_IN0:      ReadData = r_in0;
                REG_IN_STAT:  ReadData = {31'b0, r_full};
                REG_OUT_STAT: ReadData = {23'b0, w_count5, 1'b0, r_ovf, w_fifo_full, w_fifo_empty};
`ifdef IO_BRIDGE_IRQ_EN
                REG_IRQ_CTL:  ReadData = {30'b0, r_irq_ctl};
`endif
                default:      ReadData = '0;
            endcase
        end
    end

    // IN0 holding register: capture when empty, cleared by a CPU load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in0  <= '0;
            r_full <= 1'b0;
        end else if (w_in_clr) begin
            r_full <= 1'b0;
        end else if (in_valid && !r_full) begin
            r_in0  <= in_data;
            r_full <= 1'b1;
        end
    end

    // FIFO storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= PW'(r_wr_ptr + PW'(1));
            if (w_pop)     r_rd_ptr <= PW'(r_rd_ptr + PW'(1));
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_stat_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef IO_BRIDGE_IRQ_EN
    assign w_irq_wr = io_sel && MemWrite && (w_off == REG_IRQ_CTL);
    assign irq      = r_irq;

    // Interrupt enables and registered interrupt output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq_ctl <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_irq_wr) r_irq_ctl <= WriteData[1:0];
            r_irq <= (r_irq_ctl[0] && r_full) || (r_irq_ctl[1] && w_fifo_empty);
        end
    end
`endif

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: scoreboard bench for io_bridge (default parameters).
// TX bytes are queued when stored and compared when the consumer takes them.
module tb_io_bridge;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        io_sel;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef IO_BRIDGE_IRQ_EN
    logic        irq;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;

    io_bridge #(.FIFO_DEPTH(DEPTH), .IO_BASE(16'hFF00)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .io_sel(io_sel), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef IO_BRIDGE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp();
        int c = sb.size();
        return {23'b0, 5'(c), 1'b0, m_ovf, (c == DEPTH), (c == 0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [4:0] off, input logic [31:0] d);
        Addr      = BASE + 32'(off);
        WriteData = d;
        MemWrite  = 1'b1;
        if (off == 5'h08) begin
            if (sb.size() < DEPTH || out_ready) sb.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (off == 5'h0C && d[2]) m_ovf = 1'b0;
        step();
        MemWrite = 1'b0;
        Addr     = '0;
    endtask

    task automatic load(input string tag, input logic [4:0] off, input logic [31:0] exp);
        Addr    = BASE + 32'(off);
        MemRead = 1'b1;
        #1;
        check_eq(tag, ReadData, exp);
        step();
        MemRead = 1'b0;
        Addr    = '0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        out_ready = 1'b0;
        check_eq(tag, 32'(sb.size()), 32'd0);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    // Consumer side of the scoreboard: every accepted byte must match the oldest store.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) check_eq("sb_underflow", {31'b0, out_valid}, 32'd0);
            else check_eq("out_data", {24'b0, out_data}, {24'b0, sb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        rst = 1'b1;
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_data", {24'b0, out_data}, 32'd0);
        load("rst_out_stat", 5'h0C, stat_exp());
        load("rst_in_stat", 5'h04, 32'd0);
        load("unmapped", 5'h14, 32'd0);

        Addr = BASE + 32'd3;          #1; check_eq("sel_lowbits", {31'b0, io_sel}, 32'd1);
        Addr = BASE + 32'h20;         #1; check_eq("sel_above", {31'b0, io_sel}, 32'd0);
        Addr = 32'h0001_FF00;         #1; check_eq("sel_upper", {31'b0, io_sel}, 32'd0);
        Addr = 32'h0000_FF1C;         #1; check_eq("sel_top", {31'b0, io_sel}, 32'd1);
        Addr = '0;

        // IN0 capture, load-clear, and offer coinciding with the clear.
        in_data = 32'h1234_5678; in_valid = 1'b1;
        step();
        in_data = 32'hCAFE_F00D;
        check_eq("in_ready_full", {31'b0, in_ready}, 32'd0);
        load("in_stat_full", 5'h04, 32'd1);
        load("in0_word", 5'h00, 32'h1234_5678);
        check_eq("in_ready_after_clr", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("in_ready_recapture", {31'b0, in_ready}, 32'd0);
        load("in0_second", 5'h00, 32'hCAFE_F00D);
        load("in0_stale", 5'h00, 32'hCAFE_F00D);
        check_eq("in_ready_idle", {31'b0, in_ready}, 32'd1);

        // Fill past capacity with the consumer stalled.
        store(5'h08, 32'hA1);
        check_eq("first_valid", {31'b0, out_valid}, 32'd1);
        store(5'h08, 32'hB2);
        store(5'h08, 32'hC3);
        store(5'h08, 32'hD4);
        store(5'h08, 32'hE5);
        load("stat_overflow", 5'h0C, stat_exp());
        check_eq("stat_0x46", stat_exp(), 32'h46);
        check_eq("head_a1", {24'b0, out_data}, 32'hA1);

        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        check_eq("drained_valid", {31'b0, out_valid}, 32'd0);
        check_eq("drained_sb", 32'(sb.size()), 32'd0);
        store(5'h0C, 32'h4);
        load("ovf_cleared", 5'h0C, stat_exp());

        // Push while full coincident with a pop.
        store(5'h08, 32'h11);
        store(5'h08, 32'h22);
        store(5'h08, 32'h33);
        store(5'h08, 32'h44);
        out_ready = 1'b1;
        store(5'h08, 32'h77);
        out_ready = 1'b0;
        load("full_pushpop", 5'h0C, stat_exp());
        drain("drain_wrap");

        // Push and pop together at mid occupancy.
        store(5'h08, 32'h5A);
        store(5'h08, 32'h6B);
        out_ready = 1'b1;
        store(5'h08, 32'h7C);
        out_ready = 1'b0;
        load("mid_pushpop", 5'h0C, stat_exp());
        drain("drain_mid");

`ifdef IO_BRIDGE_IRQ_EN
        store(5'h10, 32'h2);
        step();
        check_eq("irq_empty", {31'b0, irq}, 32'd1);
        load("irq_ctl_rd", 5'h10, 32'd2);
        store(5'h08, 32'h55);
        step();
        check_eq("irq_cleared", {31'b0, irq}, 32'd0);
        drain("drain_irq");
`else
        store(5'h10, 32'h3);
        load("irq_ctl_zero", 5'h10, 32'd0);
`endif

        // Reset mid-operation overrides a simultaneous store and capture.
        store(5'h08, 32'h81);
        store(5'h08, 32'h92);
        in_data = 32'hDEAD_0001; in_valid = 1'b1;
        step();
        rst = 1'b0;
        Addr = BASE + 32'h08; WriteData = 32'h99; MemWrite = 1'b1; out_ready = 1'b1;
        sb.delete();
        m_ovf = 1'b0;
        step();
        rst = 1'b1; MemWrite = 1'b0; Addr = '0; in_valid = 1'b0; out_ready = 1'b0;
        check_eq("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        load("rst2_out_stat", 5'h0C, stat_exp());
        load("rst2_in0", 5'h00, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
